// File: rtl/motor_mixer_pkg.sv
// motor_mixer_pkg
//   Shared definitions for the quad-X motor mixer: datapath widths, default
//   motor limits, the one-hot mixer state encoding and the per-motor sign
//   selection used by the shared sum/clamp datapath.
package motor_mixer_pkg;

    // Width of the signed 12.4 rate commands from the rate controller.
    localparam int PID_RATE_BIT_WIDTH   = 16;
    // Width of the unsigned motor commands sent to the PWM generators.
    localparam int MOTOR_RATE_BIT_WIDTH = 8;

    localparam logic [MOTOR_RATE_BIT_WIDTH-1:0] MOTOR_MIN_DEFAULT     = 8'd10;
    localparam logic [MOTOR_RATE_BIT_WIDTH-1:0] MOTOR_MAX_DEFAULT     = 8'd255;
    localparam logic [MOTOR_RATE_BIT_WIDTH-1:0] THROTTLE_IDLE_DEFAULT = 8'd10;

    typedef enum logic [3:0] {
        MIX_IDLE     = 4'b0001,
        MIX_CALC     = 4'b0010,
        MIX_UPDATE   = 4'b0100,
        MIX_COMPLETE = 4'b1000
    } mix_state_t;

    // Sign vector {roll, pitch, yaw}; a set bit subtracts that term.
    //   m1 = T + R + P - Y   (front-left)
    //   m2 = T - R + P + Y   (front-right)
    //   m3 = T - R - P - Y   (rear-right)
    //   m4 = T + R - P + Y   (rear-left)
    function automatic logic [2:0] mix_signs(input logic [1:0] idx);
        case (idx)
            2'd0:    return 3'b001;
            2'd1:    return 3'b100;
            2'd2:    return 3'b111;
            default: return 3'b010;
        endcase
    endfunction

endpackage

// File: rtl/motor_mixer_if.sv
// motor_mixer_if
//   Bundles the rate-controller/receiver inputs and the motor command outputs
//   of the mixer.
//   master : rate controller side (drives start, armed, throttle, rates;
//            observes motor commands, busy, complete_signal)
//   slave  : mixer side
interface motor_mixer_if;
    import motor_mixer_pkg::*;

    logic                                   start_signal;
    logic                                   armed;
    logic        [MOTOR_RATE_BIT_WIDTH-1:0] throttle;
    logic signed [PID_RATE_BIT_WIDTH-1:0]   yaw_rate;
    logic signed [PID_RATE_BIT_WIDTH-1:0]   roll_rate;
    logic signed [PID_RATE_BIT_WIDTH-1:0]   pitch_rate;
    logic        [MOTOR_RATE_BIT_WIDTH-1:0] motor_1_rate;
    logic        [MOTOR_RATE_BIT_WIDTH-1:0] motor_2_rate;
    logic        [MOTOR_RATE_BIT_WIDTH-1:0] motor_3_rate;
    logic        [MOTOR_RATE_BIT_WIDTH-1:0] motor_4_rate;
    logic                                   busy;
    logic                                   complete_signal;

    modport master (
        output start_signal, armed, throttle, yaw_rate, roll_rate, pitch_rate,
        input  motor_1_rate, motor_2_rate, motor_3_rate, motor_4_rate,
        input  busy, complete_signal
    );

    modport slave (
        input  start_signal, armed, throttle, yaw_rate, roll_rate, pitch_rate,
        output motor_1_rate, motor_2_rate, motor_3_rate, motor_4_rate,
        output busy, complete_signal
    );

endinterface

// File: rtl/motor_mixer_sum_clamp.sv
// mixer_sum_clamp
//   Combinational signed mix for one motor: T +/- R +/- P +/- Y in 12.4,
//   floored to an integer and clamped to [MOTOR_MIN, MOTOR_MAX].
//   t_val, r_val, p_val, y_val : signed 12.4 operands
//   neg                        : {roll, pitch, yaw} subtract flags
//   motor                      : unsigned clamped motor command
module mixer_sum_clamp
    import motor_mixer_pkg::*;
#(
    parameter int                     RATE_WIDTH  = PID_RATE_BIT_WIDTH,
    parameter int                     MOTOR_WIDTH = MOTOR_RATE_BIT_WIDTH,
    parameter logic [MOTOR_WIDTH-1:0] MOTOR_MIN   = MOTOR_MIN_DEFAULT,
    parameter logic [MOTOR_WIDTH-1:0] MOTOR_MAX   = MOTOR_MAX_DEFAULT
) (
    input  logic signed [RATE_WIDTH-1:0]  t_val,
    input  logic signed [RATE_WIDTH-1:0]  r_val,
    input  logic signed [RATE_WIDTH-1:0]  p_val,
    input  logic signed [RATE_WIDTH-1:0]  y_val,
    input  logic        [2:0]             neg,
    output logic        [MOTOR_WIDTH-1:0] motor
);

    // Three extra bits cover four full-scale operands, so the sum never wraps.
    localparam int SUM_W = RATE_WIDTH + 3;

    localparam logic signed [SUM_W-1:0] MIN_S = SUM_W'(MOTOR_MIN);
    localparam logic signed [SUM_W-1:0] MAX_S = SUM_W'(MOTOR_MAX);

    function automatic logic [MOTOR_WIDTH-1:0] sat_motor(input logic signed [SUM_W-1:0] v);
        if (v < MIN_S)
            return MOTOR_MIN;
        else if (v > MAX_S)
            return MOTOR_MAX;
        else
            return v[MOTOR_WIDTH-1:0];
    endfunction

    logic signed [SUM_W-1:0] t_x, r_x, p_x, y_x;
    logic signed [SUM_W-1:0] sum;
    logic signed [SUM_W-1:0] whole;

    always_comb begin
        t_x = {{3{t_val[RATE_WIDTH-1]}}, t_val};
        r_x = {{3{r_val[RATE_WIDTH-1]}}, r_val};
        p_x = {{3{p_val[RATE_WIDTH-1]}}, p_val};
        y_x = {{3{y_val[RATE_WIDTH-1]}}, y_val};
        sum = t_x + (neg[2] ? -r_x : r_x)
                  + (neg[1] ? -p_x : p_x)
                  + (neg[0] ? -y_x : y_x);
        // Arithmetic shift drops the 4 fraction bits, flooring toward -inf.
        whole = sum >>> 4;
        motor = sat_motor(whole);
    end

endmodule

// File: rtl/motor_mixer.sv
// motor_mixer
//   Quad-X motor mixer. On a rising edge of start_signal it latches throttle,
//   armed and the yaw/roll/pitch rate commands, computes one motor per cycle
//   through a shared sum/clamp datapath, updates all four motor commands on
//   the same edge and then pulses complete_signal for one cycle.
//   us_clk : system clock
//   resetn : asynchronous active-low reset
//   mix    : motor_mixer_if.slave (start/armed/throttle/rates in,
//            motor_1..4_rate, busy, complete_signal out)
module motor_mixer
    import motor_mixer_pkg::*;
#(
    parameter int                     RATE_WIDTH    = PID_RATE_BIT_WIDTH,
    parameter int                     MOTOR_WIDTH   = MOTOR_RATE_BIT_WIDTH,
    parameter logic [MOTOR_WIDTH-1:0] MOTOR_MIN     = MOTOR_MIN_DEFAULT,
    parameter logic [MOTOR_WIDTH-1:0] MOTOR_MAX     = MOTOR_MAX_DEFAULT,
    parameter logic [MOTOR_WIDTH-1:0] THROTTLE_IDLE = THROTTLE_IDLE_DEFAULT
) (
    input  logic         us_clk,
    input  logic         resetn,
    motor_mixer_if.slave mix
);

    mix_state_t                   state;
    logic                         start_prev;
    logic                         armed_l;
    logic        [MOTOR_WIDTH-1:0] throttle_l;
    logic signed [RATE_WIDTH-1:0]  yaw_l;
    logic signed [RATE_WIDTH-1:0]  roll_l;
    logic signed [RATE_WIDTH-1:0]  pitch_l;
    logic        [1:0]             idx;
    logic        [MOTOR_WIDTH-1:0] stage [4];

    logic                          start_edge;
    logic signed [RATE_WIDTH-1:0]  t_val;
    logic        [MOTOR_WIDTH-1:0] sum_motor;
    logic                          force_off;

    assign start_edge = mix.start_signal & ~start_prev;
    // Throttle placed as the integer part of a 12.4 value.
    assign t_val      = RATE_WIDTH'({throttle_l, 4'b0000});
    // Disarmed or idle throttle stops the props entirely, bypassing MOTOR_MIN.
    assign force_off  = ~armed_l | (throttle_l < THROTTLE_IDLE);

    mixer_sum_clamp #(
        .RATE_WIDTH  (RATE_WIDTH),
        .MOTOR_WIDTH (MOTOR_WIDTH),
        .MOTOR_MIN   (MOTOR_MIN),
        .MOTOR_MAX   (MOTOR_MAX)
    ) u_sum_clamp (
        .t_val (t_val),
        .r_val (roll_l),
        .p_val (pitch_l),
        .y_val (yaw_l),
        .neg   (mix_signs(idx)),
        .motor (sum_motor)
    );

    always_ff @(posedge us_clk or negedge resetn) begin
        if (!resetn) begin
            state               <= MIX_IDLE;
            start_prev          <= 1'b0;
            armed_l             <= 1'b0;
            throttle_l          <= '0;
            yaw_l               <= '0;
            roll_l              <= '0;
            pitch_l             <= '0;
            idx                 <= 2'd0;
            for (int i = 0; i < 4; i++)
                stage[i] <= '0;
            mix.motor_1_rate    <= '0;
            mix.motor_2_rate    <= '0;
            mix.motor_3_rate    <= '0;
            mix.motor_4_rate    <= '0;
            mix.busy            <= 1'b0;
            mix.complete_signal <= 1'b0;
        end else begin
            start_prev <= mix.start_signal;
            unique case (state)
                MIX_IDLE: begin
                    mix.complete_signal <= 1'b0;
                    if (start_edge) begin
                        armed_l    <= mix.armed;
                        throttle_l <= mix.throttle;
                        yaw_l      <= mix.yaw_rate;
                        roll_l     <= mix.roll_rate;
                        pitch_l    <= mix.pitch_rate;
                        idx        <= 2'd0;
                        mix.busy   <= 1'b1;
                        state      <= MIX_CALC;
                    end
                end
                MIX_CALC: begin
                    stage[idx] <= force_off ? '0 : sum_motor;
                    if (idx == 2'd3)
                        state <= MIX_UPDATE;
                    else
                        idx <= idx + 2'd1;
                end
                MIX_UPDATE: begin
                    mix.motor_1_rate    <= stage[0];
                    mix.motor_2_rate    <= stage[1];
                    mix.motor_3_rate    <= stage[2];
                    mix.motor_4_rate    <= stage[3];
                    mix.busy            <= 1'b0;
                    mix.complete_signal <= 1'b1;
                    state               <= MIX_COMPLETE;
                end
                MIX_COMPLETE: begin
                    mix.complete_signal <= 1'b0;
                    state               <= MIX_IDLE;
                end
                default: begin
                    mix.busy            <= 1'b0;
                    mix.complete_signal <= 1'b0;
                    state               <= MIX_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_motor_mixer.sv
// tb_motor_mixer
//   Self-checking bench for motor_mixer: directed vector table, cycle-exact
//   hover sequence, start-protocol and mid-cycle reset sequences, then
//   randomized mixes compared against an arithmetic reference model.
module tb_motor_mixer;

    logic us_clk;
    logic resetn;
    int   errors = 0;
    int   checks = 0;

    motor_mixer_if mif ();

    motor_mixer dut (
        .us_clk (us_clk),
        .resetn (resetn),
        .mix    (mif.slave)
    );

    initial us_clk = 1'b0;
    always #5 us_clk = ~us_clk;

    typedef struct {
        string name;
        logic  armed;
        int    thr;
        int    r;
        int    p;
        int    y;
        int    e1, e2, e3, e4;
    } vec_t;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Floor of s/16 using plain integer division plus correction.
    function automatic int floor16(input int s);
        int q;
        q = s / 16;
        if ((s % 16 != 0) && (s < 0))
            q = q - 1;
        return q;
    endfunction

    // Reference mix: returns {m1, m2, m3, m4}.
    function automatic logic [31:0] model(input logic a, input int thr,
                                          input int r, input int p, input int y);
        int s [4];
        int v;
        logic [31:0] res;
        s[0] = thr * 16 + r + p - y;
        s[1] = thr * 16 - r + p + y;
        s[2] = thr * 16 - r - p - y;
        s[3] = thr * 16 + r - p + y;
        res = '0;
        for (int i = 0; i < 4; i++) begin
            v = floor16(s[i]);
            if (v < 10)  v = 10;
            if (v > 255) v = 255;
            if (!a || thr < 10) v = 0;
            res[31 - 8*i -: 8] = v[7:0];
        end
        return res;
    endfunction

    function automatic logic [31:0] outs();
        return {mif.motor_1_rate, mif.motor_2_rate, mif.motor_3_rate, mif.motor_4_rate};
    endfunction

    task automatic drive(input logic a, input int thr, input int r, input int p, input int y);
        mif.armed      = a;
        mif.throttle   = thr[7:0];
        mif.roll_rate  = r[15:0];
        mif.pitch_rate = p[15:0];
        mif.yaw_rate   = y[15:0];
    endtask

    // One complete mix: start pulse, optional input scrambling after the
    // start edge, wait (bounded) for complete_signal, then one more edge so
    // the mixer is back in IDLE.
    task automatic run_mix(input logic a, input int thr, input int r, input int p,
                           input int y, input logic scramble,
                           output logic [31:0] got, output int lat);
        int rr;
        @(negedge us_clk);
        drive(a, thr, r, p, y);
        mif.start_signal = 1'b1;
        @(posedge us_clk);
        #1;
        @(negedge us_clk);
        mif.start_signal = 1'b0;
        if (scramble) begin
            rr = int'($urandom_range(0, 65535)) - 32768;
            drive(~a, int'($urandom_range(0, 255)), rr, -rr, rr / 2);
        end
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge us_clk);
            #1;
            if (mif.complete_signal) begin
                lat = k;
                break;
            end
        end
        got = outs();
        @(posedge us_clk);
        #1;
    endtask

    task automatic count_pulses(input int n, output int pulses);
        pulses = 0;
        for (int k = 0; k < n; k++) begin
            @(posedge us_clk);
            #1;
            if (mif.complete_signal) pulses++;
        end
    endtask

    vec_t        vecs [$];
    logic [31:0] got;
    logic [31:0] exp;
    int          lat;
    int          pulses;

    initial begin
        resetn           = 1'b0;
        mif.start_signal = 1'b0;
        drive(1'b0, 0, 0, 0, 0);

        vecs.push_back('{"roll",        1'b1, 100,  256,   0,   0, 116,  84,  84, 116});
        vecs.push_back('{"clamp_hi",    1'b1, 250,    0, 512,   0, 255, 255, 218, 218});
        vecs.push_back('{"clamp_lo",    1'b1,  20,    0,   0, 512,  10,  52,  10,  52});
        vecs.push_back('{"frac_pos",    1'b1, 100,   24,   0,   0, 101,  98,  98, 101});
        vecs.push_back('{"frac_neg",    1'b1, 100,  -24,   0,   0,  98, 101, 101,  98});
        vecs.push_back('{"disarmed",    1'b0, 200,  300, 100, -50,   0,   0,   0,   0});
        vecs.push_back('{"below_idle",  1'b1,   9,    0,   0,   0,   0,   0,   0,   0});
        vecs.push_back('{"at_idle",     1'b1,  10,    0,   0,   0,  10,  10,  10,  10});

        // Reset state
        repeat (3) @(posedge us_clk);
        #1;
        chk("rst_m1", mif.motor_1_rate, 0);
        chk("rst_m2", mif.motor_2_rate, 0);
        chk("rst_m3", mif.motor_3_rate, 0);
        chk("rst_m4", mif.motor_4_rate, 0);
        chk("rst_busy", mif.busy, 0);
        chk("rst_complete", mif.complete_signal, 0);
        @(negedge us_clk);
        resetn = 1'b1;

        // Directed table
        foreach (vecs[i]) begin
            run_mix(vecs[i].armed, vecs[i].thr, vecs[i].r, vecs[i].p, vecs[i].y,
                    1'b0, got, lat);
            chk({vecs[i].name, "_lat"}, lat, 5);
            chk({vecs[i].name, "_m1"}, got[31:24], vecs[i].e1);
            chk({vecs[i].name, "_m2"}, got[23:16], vecs[i].e2);
            chk({vecs[i].name, "_m3"}, got[15:8],  vecs[i].e3);
            chk({vecs[i].name, "_m4"}, got[7:0],   vecs[i].e4);
        end

        // Hover, cycle by cycle (outputs are 10 from the last table entry)
        @(negedge us_clk);
        drive(1'b1, 100, 0, 0, 0);
        mif.start_signal = 1'b1;
        @(posedge us_clk);
        #1;
        chk("hover_busy_n", mif.busy, 1);
        @(negedge us_clk);
        mif.start_signal = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge us_clk);
            #1;
            if (k <= 4) begin
                chk($sformatf("hover_busy_%0d", k), mif.busy, 1);
                chk($sformatf("hover_cmpl_%0d", k), mif.complete_signal, 0);
                chk($sformatf("hover_hold_%0d", k), outs(), 32'h0A0A0A0A);
            end else if (k == 5) begin
                chk("hover_out", outs(), 32'h64646464);
                chk("hover_cmpl_5", mif.complete_signal, 1);
                chk("hover_busy_5", mif.busy, 0);
            end else begin
                chk("hover_cmpl_6", mif.complete_signal, 0);
            end
        end

        // Second start edge during CALC is ignored
        @(negedge us_clk);
        drive(1'b1, 120, 0, 0, 0);
        mif.start_signal = 1'b1;
        @(posedge us_clk);
        @(negedge us_clk);
        mif.start_signal = 1'b0;
        @(posedge us_clk);
        @(negedge us_clk);
        mif.start_signal = 1'b1;
        @(posedge us_clk);
        @(negedge us_clk);
        mif.start_signal = 1'b0;
        count_pulses(20, pulses);
        chk("restart_pulses", pulses, 1);
        chk("restart_out", outs(), 32'h78787878);

        // start held high: one mix only
        @(negedge us_clk);
        drive(1'b1, 90, 0, 0, 0);
        mif.start_signal = 1'b1;
        count_pulses(25, pulses);
        chk("held_pulses", pulses, 1);
        @(negedge us_clk);
        mif.start_signal = 1'b0;
        repeat (2) @(posedge us_clk);

        // Reset at N+3 aborts the mix
        @(negedge us_clk);
        drive(1'b1, 150, 0, 0, 0);
        mif.start_signal = 1'b1;
        @(posedge us_clk);
        @(negedge us_clk);
        mif.start_signal = 1'b0;
        repeat (3) @(posedge us_clk);
        #1;
        chk("pre_reset_out", outs(), 32'h5A5A5A5A);
        resetn = 1'b0;
        #1;
        chk("abort_out", outs(), 0);
        chk("abort_busy", mif.busy, 0);
        @(negedge us_clk);
        @(negedge us_clk);
        resetn = 1'b1;
        count_pulses(10, pulses);
        chk("abort_pulses", pulses, 0);
        chk("abort_hold", outs(), 0);
        run_mix(1'b1, 150, 0, 0, 0, 1'b0, got, lat);
        chk("post_reset_lat", lat, 5);
        chk("post_reset_out", got, 32'h96969696);

        // Randomized mixes, inputs scrambled after the start edge
        for (int i = 0; i < 40; i++) begin
            logic a;
            int   thr, r, p, y;
            a   = ($urandom_range(0, 7) != 0);
            thr = int'($urandom_range(0, 255));
            if (i % 2 == 0) begin
                r = int'($urandom_range(0, 65535)) - 32768;
                p = int'($urandom_range(0, 65535)) - 32768;
                y = int'($urandom_range(0, 65535)) - 32768;
            end else begin
                r = int'($urandom_range(0, 1023)) - 512;
                p = int'($urandom_range(0, 1023)) - 512;
                y = int'($urandom_range(0, 1023)) - 512;
            end
            exp = model(a, thr, r, p, y);
            run_mix(a, thr, r, p, y, 1'b1, got, lat);
            chk($sformatf("rand%0d_lat", i), lat, 5);
            chk($sformatf("rand%0d_out", i), got, exp);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/motor_mixer.md
Name: motor_mixer

Overview:
Consumes the body-frame rate-controller outputs (yaw/roll/pitch rate commands in 12.4 fixed point) plus the receiver throttle. Produces four unsigned motor commands for the PWM generators in quad-X layout. Starts on the rate controller's complete pulse, computes one motor per cycle through a shared adder/clamp datapath, then updates all four outputs at once and pulses complete_signal.

Parameters:
RATE_WIDTH, 16, width of signed 12.4 rate inputs (`PID_RATE_BIT_WIDTH)
MOTOR_WIDTH, 8, width of unsigned motor command outputs
MOTOR_MIN, 8'd10, lowest command while armed and above idle (keeps props spinning)
MOTOR_MAX, 8'd255, highest command
THROTTLE_IDLE, 8'd10, throttle below this forces all motors to 0

Ports:
us_clk  in  1  1 MHz system clock
resetn  in  1  async active-low reset
start_signal  in  1  from body_frame_controller complete; rising edge starts a mix cycle
armed  in  1  1 = flight enabled; 0 forces motor outputs to 0
throttle  in  8  unsigned collective throttle, 0..255
yaw_rate  in  16  signed 12.4 yaw command
roll_rate  in  16  signed 12.4 roll command
pitch_rate  in  16  signed 12.4 pitch command
motor_1_rate  out  8  front-left command
motor_2_rate  out  8  front-right command
motor_3_rate  out  8  rear-right command
motor_4_rate  out  8  rear-left command
busy  out  1  high in CALC and UPDATE
complete_signal  out  1  one-cycle pulse when new outputs are valid

Behaviour:
- Reset (async, resetn low): all motor outputs 0, busy 0, complete_signal 0, state IDLE, latched inputs 0, index 0, start edge register 0. Reset mid-operation aborts the cycle; no partial output update.
- start_prev register holds the previous start_signal value; start edge = start_signal & ~start_prev.
- States:
  - IDLE: a start edge latches throttle, armed and all three rates, clears index, and goes to CALC.
  - CALC: one motor per cycle, index 0..3, results into staging regs; after index 3 goes to UPDATE.
  - UPDATE: copies staging regs to the four outputs in the same edge, then goes to COMPLETE.
  - COMPLETE: complete_signal = 1 for exactly one cycle, then IDLE.
- Timing: start edge sampled at edge N; CALC occupies N+1..N+4; outputs change at edge N+5; complete_signal high during cycle N+6. Total 6 cycles.
- Start edges outside IDLE are ignored and not queued. start_signal held high does not retrigger; it must go low first.
- Mixing, with T = {4'b0, throttle, 4'b0} in 12.4 and signs fixed:
  - m1 = T + R + P - Y
  - m2 = T - R + P + Y
  - m3 = T - R - P - Y
  - m4 = T + R - P + Y
- Arithmetic: all operands sign-extended to 19 bits before summing, so no overflow is possible. The result is arithmetic-shifted right by 4 (floor toward -inf), then clamped to [MOTOR_MIN, MOTOR_MAX].
- Override: if latched armed = 0, or latched throttle < THROTTLE_IDLE, every staging value is 0. No MOTOR_MIN floor applies in that case.
- Outputs hold their values between cycles. Inputs may change freely after the start edge because only latched copies are used.

Decomposition:
- common_defines.v holds:
  - `PID_RATE_BIT_WIDTH (16) and `MOTOR_RATE_BIT_WIDTH (8).
  - MOTOR_MIN/MAX/THROTTLE_IDLE defaults.
  - Mixer state encodings, one-hot 4'b0001 IDLE, 4'b0010 CALC, 4'b0100 UPDATE, 4'b1000 COMPLETE.
- One sub-module, mixer_sum_clamp: combinational signed sum + shift + clamp for one motor. Inputs are T, R, P, Y and a 3-bit sign vector selected by index.

Test Plan:
- Hover: armed=1, throttle=100, all rates 0, start pulse -> all motors 100 at edge N+5; complete_signal 1 cycle at N+6; busy high N+1..N+5.
- Roll: throttle=100, roll_rate=16'h0100 (16.0) -> m1=116, m2=84, m3=84, m4=116.
- Clamps: throttle=250, pitch_rate=16'h0200 -> m1=m2=255, m3=m4=218. Then throttle=20, yaw_rate=16'h0200 -> m1=m3=10 (MOTOR_MIN), m2=m4=52.
- Fraction/floor: throttle=100, roll_rate=16'h0018 (1.5) -> m1=m4=101, m2=m3=98. roll_rate=16'hFFE8 (-1.5) -> m1=m4=98, m2=m3=101.
- Disarm/idle: armed=0, throttle=200 -> all 0. armed=1, throttle=9 -> all 0. throttle=10 -> all 10.
- Protocol: second start edge at N+2 ignored (exactly one complete pulse); start held high 20 cycles -> one cycle only. resetn low at N+3 -> outputs 0 immediately, no complete pulse; next start after reset works normally.
